// File: rtl/vga_mode_ctrl.sv
// vga_mode_ctrl: 4-entry VGA timing table, pixel-clock enable and
// frame-aligned mode switching for the horizontal/vertical sync-calc counters.
// Entries 0/1 are fixed modes, entries 2/3 are CPU-writable and must be
// completed with a DIV write before they can be selected.
module vga_mode_ctrl #(
    parameter int HOLD_CYC = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MODE_REQ,
    input  logic [1:0]  MODE_SEL,
    output logic        MODE_ACK,
    output logic        MODE_ERR,
    output logic        BUSY,
    output logic [1:0]  MODE_CUR,
    input  logic        CFG_WE,
    input  logic        CFG_ENTRY,
    input  logic [3:0]  CFG_FIELD,
    input  logic [11:0] CFG_DATA,
    input  logic        FRAME_END,
    output logic [11:0] H_VIS,
    output logic [7:0]  H_FRONT,
    output logic [7:0]  H_SYNC,
    output logic [7:0]  H_BACK,
    output logic [11:0] V_VIS,
    output logic [7:0]  V_FRONT,
    output logic [7:0]  V_SYNC,
    output logic [7:0]  V_BACK,
    output logic        P_CLK_EN,
    output logic        TG_RST_N,
    output logic        VIDEO_EN
);

    typedef struct packed {
        logic [11:0] h_vis;
        logic [7:0]  h_front;
        logic [7:0]  h_sync;
        logic [7:0]  h_back;
        logic [11:0] v_vis;
        logic [7:0]  v_front;
        logic [7:0]  v_sync;
        logic [7:0]  v_back;
        logic [2:0]  div;
    } timing_t;

    typedef enum logic [1:0] {S_INIT, S_RUN, S_WAIT, S_HOLD} state_t;

    localparam timing_t MODE0 = '{12'd640, 8'd16, 8'd96, 8'd48,
                                  12'd480, 8'd10, 8'd2,  8'd33, 3'd2};
    localparam timing_t MODE1 = '{12'd800, 8'd56, 8'd120, 8'd64,
                                  12'd600, 8'd37, 8'd6,   8'd23, 3'd1};
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYC - 1);

    // Merge one config field into a table entry; unknown fields leave it as is.
    function automatic timing_t wr_field(timing_t t, logic [3:0] f, logic [11:0] d);
        timing_t r;
        r = t;
        case (f)
            4'd0: r.h_vis   = d;
            4'd1: r.h_front = d[7:0];
            4'd2: r.h_sync  = d[7:0];
            4'd3: r.h_back  = d[7:0];
            4'd4: r.v_vis   = d;
            4'd5: r.v_front = d[7:0];
            4'd6: r.v_sync  = d[7:0];
            4'd7: r.v_back  = d[7:0];
            4'd8: r.div     = d[2:0];
            default: ;
        endcase
        return r;
    endfunction

    state_t      state, state_nxt;
    logic [3:0]  hold_cnt;
    logic [1:0]  target, mode_cur;
    timing_t     cur, tbl2, tbl3, tgt_timing;
    logic        vld2, vld3;
    logic [2:0]  div_cnt, div_cnt_nxt, div_eff;
    logic        tg_rst_n_q, video_en_q, busy_q, p_en_q, p_en_nxt;
    logic        sel_valid, switch_go, hold_done, run_now, run_nxt;
    logic [1:0]  cfg_idx;
    logic        cfg_do;

    assign sel_valid = (MODE_SEL == 2'd2) ? vld2 :
                       (MODE_SEL == 2'd3) ? vld3 : 1'b1;
    // Request handshake is decided in the cycle the request is seen.
    assign MODE_ACK  = (state == S_RUN) && MODE_REQ && sel_valid;
    assign MODE_ERR  = (state == S_RUN) && MODE_REQ && !sel_valid;
    assign switch_go = MODE_ACK && (MODE_SEL != mode_cur);
    assign hold_done = (hold_cnt == HOLD_LAST);
    assign run_now   = (state == S_RUN) || (state == S_WAIT);
    assign run_nxt   = (state_nxt == S_RUN) || (state_nxt == S_WAIT);
    assign div_eff   = (cur.div == 3'd0) ? 3'd1 : cur.div;

    // The active entry and a pending target are frozen against config writes.
    assign cfg_idx = {1'b1, CFG_ENTRY};
    assign cfg_do  = CFG_WE && (CFG_FIELD <= 4'd8) && (cfg_idx != mode_cur)
                     && !(busy_q && (cfg_idx == target));

    // Next-state: reset hold, run, wait for frame boundary, reset hold again.
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT: if (hold_done) state_nxt = S_RUN;
            S_RUN:  if (switch_go) state_nxt = S_WAIT;
            S_WAIT: if (FRAME_END) state_nxt = S_HOLD;
            S_HOLD: if (hold_done) state_nxt = S_RUN;
            default: state_nxt = S_INIT;
        endcase
    end

    // Table lookup for the latched switch target.
    always_comb begin
        tgt_timing = MODE0;
        case (target)
            2'd0: tgt_timing = MODE0;
            2'd1: tgt_timing = MODE1;
            2'd2: tgt_timing = tbl2;
            2'd3: tgt_timing = tbl3;
            default: tgt_timing = MODE0;
        endcase
    end

    // Divider restarts at 0 on every entry into run so the first pixel
    // enable lands DIV cycles after the timing generator leaves reset.
    always_comb begin
        div_cnt_nxt = 3'd0;
        if (run_nxt && run_now && (div_cnt != 3'(div_eff - 3'd1)))
            div_cnt_nxt = div_cnt + 3'd1;
        p_en_nxt = run_nxt && (div_cnt_nxt == 3'(div_eff - 3'd1));
    end

    // State register and reset-hold counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= S_INIT;
            hold_cnt <= 4'd0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                hold_cnt <= 4'd0;
            else if ((state == S_INIT) || (state == S_HOLD))
                hold_cnt <= hold_cnt + 4'd1;
        end
    end

    // Target latch; timing and MODE_CUR swap only on the edge into HOLD.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            target   <= 2'd0;
            mode_cur <= 2'd0;
            cur      <= MODE0;
        end else begin
            if (switch_go)
                target <= MODE_SEL;
            if ((state == S_WAIT) && FRAME_END) begin
                mode_cur <= target;
                cur      <= tgt_timing;
            end
        end
    end

    // Registered control outputs and pixel-enable divider.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tg_rst_n_q <= 1'b0;
            video_en_q <= 1'b0;
            busy_q     <= 1'b1;
            p_en_q     <= 1'b0;
            div_cnt    <= 3'd0;
        end else begin
            tg_rst_n_q <= run_nxt;
            video_en_q <= run_nxt;
            busy_q     <= (state_nxt != S_RUN);
            p_en_q     <= p_en_nxt;
            div_cnt    <= div_cnt_nxt;
        end
    end

    // Writable entries: any timing field invalidates, DIV completes the entry.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tbl2 <= '0;
            tbl3 <= '0;
            vld2 <= 1'b0;
            vld3 <= 1'b0;
        end else if (cfg_do) begin
            if (CFG_ENTRY) begin
                tbl3 <= wr_field(tbl3, CFG_FIELD, CFG_DATA);
                vld3 <= (CFG_FIELD == 4'd8);
            end else begin
                tbl2 <= wr_field(tbl2, CFG_FIELD, CFG_DATA);
                vld2 <= (CFG_FIELD == 4'd8);
            end
        end
    end

    assign BUSY     = busy_q;
    assign MODE_CUR = mode_cur;
    assign TG_RST_N = tg_rst_n_q;
    assign VIDEO_EN = video_en_q;
    assign P_CLK_EN = p_en_q;
    assign H_VIS    = cur.h_vis;
    assign H_FRONT  = cur.h_front;
    assign H_SYNC   = cur.h_sync;
    assign H_BACK   = cur.h_back;
    assign V_VIS    = cur.v_vis;
    assign V_FRONT  = cur.v_front;
    assign V_SYNC   = cur.v_sync;
    assign V_BACK   = cur.v_back;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Bench for vga_mode_ctrl: directed walk through the mode-switch scenarios,
// then randomized traffic, all compared every cycle against a phase model.
module tb_vga_mode_ctrl;
    localparam int HOLD = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        MODE_REQ = 1'b0;
    logic [1:0]  MODE_SEL = 2'd0;
    logic        CFG_WE = 1'b0;
    logic        CFG_ENTRY = 1'b0;
    logic [3:0]  CFG_FIELD = 4'd0;
    logic [11:0] CFG_DATA = 12'd0;
    logic        FRAME_END = 1'b0;
    logic        MODE_ACK, MODE_ERR, BUSY, P_CLK_EN, TG_RST_N, VIDEO_EN;
    logic [1:0]  MODE_CUR;
    logic [11:0] H_VIS, V_VIS;
    logic [7:0]  H_FRONT, H_SYNC, H_BACK, V_FRONT, V_SYNC, V_BACK;

    int checks = 0;
    int errors = 0;

    vga_mode_ctrl #(.HOLD_CYC(HOLD)) dut (
        .CLK(CLK), .RST(RST), .MODE_REQ(MODE_REQ), .MODE_SEL(MODE_SEL),
        .MODE_ACK(MODE_ACK), .MODE_ERR(MODE_ERR), .BUSY(BUSY), .MODE_CUR(MODE_CUR),
        .CFG_WE(CFG_WE), .CFG_ENTRY(CFG_ENTRY), .CFG_FIELD(CFG_FIELD),
        .CFG_DATA(CFG_DATA), .FRAME_END(FRAME_END),
        .H_VIS(H_VIS), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_VIS(V_VIS), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
        .P_CLK_EN(P_CLK_EN), .TG_RST_N(TG_RST_N), .VIDEO_EN(VIDEO_EN)
    );

    always #10 CLK = ~CLK;

    // Model: phase 0 init, 1 run, 2 waiting for frame end, 3 hold.
    int m_ph, m_cnt, m_age, m_cur, m_tgt;
    int m_tbl[4][9];
    bit m_vld[4];
    int m_act[9];

    function automatic void m_reset();
        m_tbl[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
        m_tbl[1] = '{800, 56, 120, 64, 600, 37, 6, 23, 1};
        m_tbl[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        m_tbl[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        m_vld = '{1'b1, 1'b1, 1'b0, 1'b0};
        m_act = m_tbl[0];
        m_ph = 0; m_cnt = 0; m_age = 0; m_cur = 0; m_tgt = 0;
    endfunction

    function automatic void m_step();
        bit v0, busy0;
        int cur0, tgt0, idx, f;
        v0 = m_vld[MODE_SEL]; busy0 = (m_ph != 1); cur0 = m_cur; tgt0 = m_tgt;
        case (m_ph)
            0, 3: begin
                m_cnt++;
                if (m_cnt == HOLD) begin m_ph = 1; m_age = 0; end
            end
            1: begin
                m_age++;
                if (MODE_REQ && v0 && (int'(MODE_SEL) != m_cur)) begin
                    m_tgt = MODE_SEL; m_ph = 2;
                end
            end
            default: begin
                m_age++;
                if (FRAME_END) begin
                    m_ph = 3; m_cnt = 0; m_cur = m_tgt; m_act = m_tbl[m_tgt];
                end
            end
        endcase
        idx = 2 + int'(CFG_ENTRY);
        f = CFG_FIELD;
        if (CFG_WE && f <= 8 && idx != cur0 && !(busy0 && idx == tgt0)) begin
            m_tbl[idx][f] = (f == 0 || f == 4) ? (CFG_DATA & 12'hFFF) :
                            (f == 8) ? (CFG_DATA & 7) : (CFG_DATA & 8'hFF);
            m_vld[idx] = (f == 8);
        end
    endfunction

    function automatic logic [79:0] exp_vec();
        bit run, pe, ack, err;
        int d;
        run = (m_ph == 1 || m_ph == 2);
        d = (m_act[8] == 0) ? 1 : m_act[8];
        pe = run && ((m_age % d) == d - 1);
        ack = (m_ph == 1) && MODE_REQ && m_vld[MODE_SEL];
        err = (m_ph == 1) && MODE_REQ && !m_vld[MODE_SEL];
        return {ack, err, (m_ph != 1), 2'(m_cur), run, run, pe,
                12'(m_act[0]), 8'(m_act[1]), 8'(m_act[2]), 8'(m_act[3]),
                12'(m_act[4]), 8'(m_act[5]), 8'(m_act[6]), 8'(m_act[7])};
    endfunction

    logic [79:0] dut_vec;
    assign dut_vec = {MODE_ACK, MODE_ERR, BUSY, MODE_CUR, TG_RST_N, VIDEO_EN, P_CLK_EN,
                      H_VIS, H_FRONT, H_SYNC, H_BACK, V_VIS, V_FRONT, V_SYNC, V_BACK};

    // Per-cycle compare on the falling edge, then advance the model.
    always @(negedge CLK) begin
        logic [79:0] e;
        if (!RST) m_reset();
        e = exp_vec();
        checks++;
        if (dut_vec !== e) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t dut=%h expected=%h (ph=%0d)", $time, dut_vec, e, m_ph);
        end
        if (RST) m_step();
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic e, input int f, input int d);
        CFG_WE = 1'b1; CFG_ENTRY = e; CFG_FIELD = 4'(f); CFG_DATA = 12'(d);
        tick();
        CFG_WE = 1'b0;
    endtask

    task automatic do_switch(input int sel);
        MODE_SEL = 2'(sel); MODE_REQ = 1'b1;
        tick();
        MODE_REQ = 1'b0;
        repeat (2) tick();
        FRAME_END = 1'b1;
        tick();
        FRAME_END = 1'b0;
        repeat (HOLD + 1) tick();
    endtask

    initial begin
        int e2[9];
        int e3[9];
        e2 = '{320, 8, 48, 24, 240, 5, 2, 15, 4};
        e3 = '{400, 12, 40, 20, 300, 3, 4, 9, 3};

        repeat (3) tick();
        chk("rst_tg_rst_n", TG_RST_N, 0);
        chk("rst_busy", BUSY, 1);
        chk("rst_h_vis", H_VIS, 640);
        RST = 1'b1;
        repeat (3) tick();
        chk("init_hold_tg", TG_RST_N, 0);
        tick();
        chk("init_done_tg", TG_RST_N, 1);
        chk("m0_h_vis", H_VIS, 640);
        chk("m0_v_back", V_BACK, 33);
        chk("m0_mode_cur", MODE_CUR, 0);
        chk("m0_pclk_a", P_CLK_EN, 0);
        tick();
        chk("m0_pclk_b", P_CLK_EN, 1);

        // Switch to entry 1 at a frame boundary.
        MODE_SEL = 2'd1; MODE_REQ = 1'b1;
        #1 chk("m1_ack", MODE_ACK, 1);
        tick();
        MODE_REQ = 1'b0;
        chk("m1_busy", BUSY, 1);
        repeat (5) tick();
        chk("m1_wait_h_front", H_FRONT, 16);
        chk("m1_wait_tg", TG_RST_N, 1);
        FRAME_END = 1'b1;
        tick();
        FRAME_END = 1'b0;
        chk("m1_hold_tg", TG_RST_N, 0);
        chk("m1_hold_video", VIDEO_EN, 0);
        chk("m1_h_front", H_FRONT, 56);
        chk("m1_mode_cur", MODE_CUR, 1);
        repeat (HOLD) tick();
        chk("m1_run_tg", TG_RST_N, 1);
        chk("m1_busy_clr", BUSY, 0);
        chk("m1_pclk", P_CLK_EN, 1);

        // Unconfigured entry 2 is rejected; configure it and switch.
        MODE_SEL = 2'd2; MODE_REQ = 1'b1;
        #1 chk("e2_err", MODE_ERR, 1);
        tick();
        MODE_REQ = 1'b0;
        chk("e2_err_busy", BUSY, 0);
        for (int f = 0; f < 9; f++) cfg_write(1'b0, f, e2[f]);
        MODE_SEL = 2'd2; MODE_REQ = 1'b1;
        tick();
        MODE_REQ = 1'b0;
        repeat (3) tick();
        FRAME_END = 1'b1;
        tick();
        FRAME_END = 1'b0;
        repeat (HOLD) tick();
        chk("e2_h_vis", H_VIS, 320);
        chk("e2_mode_cur", MODE_CUR, 2);
        chk("e2_pclk_a", P_CLK_EN, 0);
        repeat (3) tick();
        chk("e2_pclk_b", P_CLK_EN, 1);

        // Entry 3 invalidated by a late rewrite; writes to the active entry dropped.
        for (int f = 0; f < 9; f++) cfg_write(1'b1, f, e3[f]);
        cfg_write(1'b1, 3, 77);
        MODE_SEL = 2'd3; MODE_REQ = 1'b1;
        #1 chk("e3_err", MODE_ERR, 1);
        tick();
        MODE_REQ = 1'b0;
        cfg_write(1'b0, 0, 999);
        do_switch(1);
        do_switch(2);
        chk("e2_back_h_vis", H_VIS, 320);

        // Same-mode request and stray frame end leave timing running.
        MODE_SEL = 2'd2; MODE_REQ = 1'b1;
        #1 chk("same_ack", MODE_ACK, 1);
        repeat (2) tick();
        MODE_REQ = 1'b0;
        chk("same_tg", TG_RST_N, 1);
        FRAME_END = 1'b1;
        tick();
        FRAME_END = 1'b0;
        tick();
        chk("stray_fe_tg", TG_RST_N, 1);

        // Reset in the middle of HOLD.
        MODE_SEL = 2'd1; MODE_REQ = 1'b1;
        tick();
        MODE_REQ = 1'b0;
        FRAME_END = 1'b1;
        tick();
        FRAME_END = 1'b0;
        tick();
        RST = 1'b0;
        #1;
        chk("abort_mode_cur", MODE_CUR, 0);
        chk("abort_tg", TG_RST_N, 0);
        chk("abort_h_vis", H_VIS, 640);
        repeat (2) tick();
        RST = 1'b1;
        repeat (HOLD + 1) tick();
        MODE_SEL = 2'd2; MODE_REQ = 1'b1;
        #1 chk("abort_e2_invalid", MODE_ERR, 1);
        tick();
        MODE_REQ = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            MODE_REQ  = ($urandom_range(0, 7) == 0);
            MODE_SEL  = 2'($urandom_range(0, 3));
            CFG_WE    = ($urandom_range(0, 5) == 0);
            CFG_ENTRY = 1'($urandom_range(0, 1));
            CFG_FIELD = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
            CFG_DATA  = 12'($urandom);
            FRAME_END = ($urandom_range(0, 24) == 0);
            RST       = ($urandom_range(0, 799) != 0);
            tick();
        end
        RST = 1'b1; MODE_REQ = 1'b0; CFG_WE = 1'b0; FRAME_END = 1'b0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_mode_ctrl.md
Name: vga_mode_ctrl

Overview:
- Mode/timing controller for the VGA horizontal and vertical sync-calc counters.
- Holds a 4-entry timing table and drives VIS/FRONT/SYNC/BACK for both axes.
- Generates the pixel-clock enable and sequences glitch-free mode switches at frame boundaries by holding the timing generator in reset.
- Sits between the CPU/config logic and the two sync-calc instances.

Parameters:
HOLD_CYC, 4, CLK cycles the timing generator is held in reset after power-up or a mode switch (1..15).

Ports:
CLK  in  1  system clock (50 MHz)
RST  in  1  asynchronous active-low reset
MODE_REQ  in  1  mode change request (level)
MODE_SEL  in  2  requested table entry
MODE_ACK  out  1  1-cycle pulse: request accepted
MODE_ERR  out  1  1-cycle pulse: request rejected (invalid entry)
BUSY  out  1  switch in progress
MODE_CUR  out  2  entry currently driving timing
CFG_WE  in  1  table write strobe
CFG_ENTRY  in  1  0 = entry 2, 1 = entry 3
CFG_FIELD  in  4  0 H_VIS, 1 H_FRONT, 2 H_SYNC, 3 H_BACK, 4 V_VIS, 5 V_FRONT, 6 V_SYNC, 7 V_BACK, 8 DIV
CFG_DATA  in  12  write data (low 8 bits for FRONT/SYNC/BACK, low 3 for DIV)
FRAME_END  in  1  1-cycle end-of-frame pulse from vertical counter (CLK domain)
H_VIS, V_VIS  out  12  visible counts
H_FRONT, H_SYNC, H_BACK, V_FRONT, V_SYNC, V_BACK  out  8 each  porch/sync counts
P_CLK_EN  out  1  pixel enable, 1 pulse per DIV CLK cycles
TG_RST_N  out  1  active-low reset to sync-calc instances
VIDEO_EN  out  1  1 = pixel output allowed

Behaviour:
- Table entries:
  - Entry 0 is fixed 640x480: H 640/16/96/48, V 480/10/2/33, DIV 2.
  - Entry 1 is fixed 800x600: H 800/56/120/64, V 600/37/6/23, DIV 1.
  - Entries 2 and 3 are writable; each has a valid bit that is cleared on reset.
- Config writes:
  - A CFG_WE write to field 0..7 stores the data and clears that entry's valid bit.
  - A write to field 8 stores DIV and sets valid.
  - Field 9..15 writes are ignored.
  - A write to the entry equal to MODE_CUR, or to the pending target while BUSY, is ignored entirely (no storage, valid unchanged).
- DIV: 0 is treated as 1. The divider counter runs 0..DIV-1, and P_CLK_EN=1 when the counter equals DIV-1. With DIV=1, P_CLK_EN is constantly 1.
- Reset values:
  - MODE_CUR=0; outputs carry entry 0 parameters.
  - TG_RST_N=0, VIDEO_EN=0, BUSY=1.
  - MODE_ACK=0, MODE_ERR=0, P_CLK_EN=0, divider counter=0.
- FSM states: INIT, RUN, WAIT_FRAME, HOLD.
  - INIT: TG_RST_N=0. After HOLD_CYC cycles go to RUN.
  - RUN: TG_RST_N=1, VIDEO_EN=1, BUSY=0. When MODE_REQ=1:
    - Invalid entry: MODE_ERR pulses, stay in RUN.
    - MODE_SEL==MODE_CUR: MODE_ACK pulses, stay in RUN, no disturbance.
    - Otherwise: latch target, MODE_ACK pulses, BUSY=1 from the next cycle, go to WAIT_FRAME.
  - WAIT_FRAME: output still active on the old mode; MODE_REQ is ignored. On FRAME_END go to HOLD in the next cycle.
  - HOLD: TG_RST_N=0 and VIDEO_EN=0 from the HOLD entry cycle. Timing outputs, DIV and MODE_CUR load the target on entry. Divider counter cleared, P_CLK_EN=0 during HOLD. After HOLD_CYC cycles go to RUN.
- TG_RST_N, VIDEO_EN, BUSY and P_CLK_EN are registered outputs. Timing outputs change only on INIT/HOLD entry and are never changed while TG_RST_N=1.
- While a request is held high in RUN with an error or same-mode result, the pulse repeats every cycle; requesters must drop MODE_REQ on ACK/ERR.
- FRAME_END outside WAIT_FRAME is ignored.
- RST asserted mid-switch aborts the switch and returns to the reset values above (entry 0, entries 2/3 invalid).

Test Plan:
- Release reset, HOLD_CYC=4 -> TG_RST_N low 4 cycles then high. MODE_CUR=0, H_VIS=640, V_BACK=33, P_CLK_EN toggles 1-of-2.
- In RUN, MODE_SEL=1 request -> MODE_ACK 1 cycle, BUSY=1, outputs unchanged until FRAME_END. Then TG_RST_N=0 and VIDEO_EN=0 for 4 cycles, H_FRONT=56, P_CLK_EN constant 1, MODE_CUR=1, BUSY=0.
- Request entry 2 before configuring -> MODE_ERR pulse, no BUSY. Write fields 0..8 of entry 2 (320/8/48/24, 240/5/2/15, DIV 4), request -> accepted, switch at FRAME_END, P_CLK_EN 1-of-4.
- Rewrite field 3 of entry 3 after valid -> valid cleared, request 3 rejected. Write to the active entry -> ignored, readback values unchanged after switch-away/back.
- Request same mode as MODE_CUR -> MODE_ACK only, TG_RST_N stays 1, no blanking. FRAME_END pulses in RUN -> no effect.
- Assert RST during HOLD -> immediate TG_RST_N=0, MODE_CUR=0, entry 0 timing, entries 2/3 invalid.
